// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - up/down Gray-code counter with load, binary/Gray registered outputs and wrap pulse
// Optional saturate-at-limit behaviour enabled by defining GRAY_COUNTER_SAT_EN.
module gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_bin_out,
  output logic [WIDTH-1:0] o_gray_out,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;

  logic             w_at_max;
  logic             w_at_min;
  logic             w_term;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_bin_next;
  logic             w_wrap_next;

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  assign w_at_max = &r_bin;
  assign w_at_min = ~|r_bin;
  assign w_term   = i_en & (i_up ? w_at_max : w_at_min);
  assign w_step   = i_up ? (r_bin + ONE) : (r_bin - ONE);

  // Load outranks counting; the terminal-count pulse only comes from an enabled step.
  always_comb begin
    w_bin_next  = r_bin;
    w_wrap_next = 1'b0;
    if (i_load) begin
      w_bin_next = i_load_val;
    end else if (i_en) begin
      w_wrap_next = w_term;
`ifdef GRAY_COUNTER_SAT_EN
      if (!w_term) begin
        w_bin_next = w_step;
      end
`else
      w_bin_next = w_step;
`endif
    end
  end

  // Gray is encoded from the next binary value so both outputs update on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= bin2gray(w_bin_next);
      r_wrap <= w_wrap_next;
    end
  end

  assign o_bin_out  = r_bin;
  assign o_gray_out = r_gray;
  assign o_wrap     = r_wrap;

endmodule

// File: tb/tb_gray_counter.sv
// tb/tb_gray_counter.sv - scoreboard bench for gray_counter at WIDTH=4 and WIDTH=12
// Reference model honours GRAY_COUNTER_SAT_EN when defined.
module tb_gray_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        up = 1'b0;
  logic        load = 1'b0;
  logic [11:0] lv = '0;

  logic [3:0]  b4, g4;
  logic        w4;
  logic [11:0] b12, g12;
  logic        w12;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_load(load),
    .i_load_val(lv[3:0]), .o_bin_out(b4), .o_gray_out(g4), .o_wrap(w4)
  );

  gray_counter #(.WIDTH(12)) dut12 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_load(load),
    .i_load_val(lv), .o_bin_out(b12), .o_gray_out(g12), .o_wrap(w12)
  );

  typedef struct {
    logic [31:0] b4;
    logic [31:0] g4;
    logic        w4;
    logic [31:0] b12;
    logic [31:0] g12;
    logic        w12;
    logic        chg4;
    logic        chg12;
    logic        step;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_err = 0;

  logic [31:0] m_b4 = 0;
  logic [31:0] m_b12 = 0;

  function automatic logic sat_build();
`ifdef GRAY_COUNTER_SAT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Behavioural rules: integer count modulo 2^w, terminal count at the range ends.
  function automatic void model(input int w, input logic [31:0] b, input logic r, input logic l,
                                input logic [31:0] val, input logic e, input logic u,
                                output logic [31:0] nb, output logic wr);
    logic [31:0] mask;
    logic        term;
    mask = (32'd1 << w) - 32'd1;
    nb = b;
    wr = 1'b0;
    if (r) begin
      nb = 0;
    end else if (l) begin
      nb = val & mask;
    end else if (e) begin
      term = u ? (b == mask) : (b == 0);
      wr = term;
      if (!(term && sat_build()))
        nb = u ? ((b + 1) & mask) : ((b + mask) & mask);
    end
  endfunction

  function automatic logic [31:0] to_gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic drive(input logic r, input logic l, input logic [11:0] val,
                       input logic e, input logic u);
    exp_t x;
    logic [31:0] nb4, nb12;
    logic wr4, wr12;
    @(negedge clk);
    rst = r; load = l; lv = val; en = e; up = u;
    model(4, m_b4, r, l, {20'd0, val}, e, u, nb4, wr4);
    model(12, m_b12, r, l, {20'd0, val}, e, u, nb12, wr12);
    x.b4 = nb4;  x.g4 = to_gray(nb4);  x.w4 = wr4;
    x.b12 = nb12; x.g12 = to_gray(nb12); x.w12 = wr12;
    x.chg4 = (nb4 != m_b4);
    x.chg12 = (nb12 != m_b12);
    x.step = !r && !l && e;
    m_b4 = nb4;
    m_b12 = nb12;
    exp_q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [3:0]  prev_g4 = '0;
  logic [11:0] prev_g12 = '0;

  always @(posedge clk) begin
    exp_t x;
    #2;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk("bin4", {28'd0, b4}, x.b4);
      chk("gray4", {28'd0, g4}, x.g4);
      chk("wrap4", {31'd0, w4}, {31'd0, x.w4});
      chk("bin12", {20'd0, b12}, x.b12);
      chk("gray12", {20'd0, g12}, x.g12);
      chk("wrap12", {31'd0, w12}, {31'd0, x.w12});
      chk("enc12", {20'd0, g12}, {20'd0, b12 ^ (b12 >> 1)});
      if (x.step) begin
        chk("ham4", $countones(g4 ^ prev_g4), x.chg4 ? 32'd1 : 32'd0);
        chk("ham12", $countones(g12 ^ prev_g12), x.chg12 ? 32'd1 : 32'd0);
      end
    end
    prev_g4 = g4;
    prev_g12 = g12;
  end

  initial begin
    logic r_r, r_l, r_e, r_u;
    logic [11:0] r_v;
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (17) drive(0, 0, 0, 1, 1);
    drive(0, 1, 12'h005, 0, 0);
    repeat (6) drive(0, 0, 0, 1, 0);
    drive(0, 1, 12'h00A, 1, 1);
    drive(0, 1, 12'h000, 0, 0);
    repeat (7) drive(0, 0, 0, 1, 1);
    drive(1, 0, 0, 1, 1);
    repeat (3) drive(0, 0, 0, 1, 1);
    drive(0, 1, 12'h00F, 0, 0);
    repeat (3) drive(0, 0, 0, 1, 1);
    drive(0, 1, 12'h000, 0, 0);
    repeat (2) drive(0, 0, 0, 1, 0);
    drive(0, 1, 12'hFFE, 0, 0);
    repeat (4) drive(0, 0, 0, 1, 1);
    repeat (10000) begin
      r_r = ($urandom_range(0, 199) == 0);
      r_l = ($urandom_range(0, 15) == 0);
      r_e = ($urandom_range(0, 3) != 0);
      r_u = ($urandom_range(0, 3) != 0);
      r_v = 12'($urandom);
      drive(r_r, r_l, r_v, r_e, r_u);
    end
    drive(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    chk("drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
# gray_counter

Parametrised up/down Gray-code counter with synchronous load, dual binary/Gray registered outputs and a terminal-count pulse. It supersedes the fixed 4-bit combinational binary-to-Gray gate network. It is the standard source of single-bit-change count values for pointers, position encoders and pointers that cross into other clock domains. Binary-to-Gray encoding is applied to the load value and the next state; every output is registered.

## Interface
Parameters:
- WIDTH, 4, counter width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  count enable; advances the counter by one step per cycle while high
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1
- load  input  1  synchronous load strobe
- load_val  input  WIDTH  binary value to load
- bin_out  output  WIDTH  current count in binary
- gray_out  output  WIDTH  current count in Gray code: gray_out = bin_out ^ (bin_out >> 1)
- wrap  output  1  one-cycle pulse marking a terminal-count event

## Operation
- Internal state is the binary count B, which is WIDTH bits wide. gray_out is computed from next-B and registered in the same edge, so the two outputs are always consistent.
- Priority per rising edge of clk:
  - 1. rst: B=0, gray_out=0, wrap=0.
  - 2. load: B=load_val and gray_out=enc(load_val). wrap=0 and en is ignored.
  - 3. en with up=1: B=B+1 modulo 2^WIDTH.
  - 4. en with up=0: B=B-1 modulo 2^WIDTH.
  - 5. Otherwise hold; wrap=0.
- Terminal-count event:
  - Counting up, the event is en=1, up=1 and B=2^WIDTH-1.
  - Counting down, the event is en=1, up=0 and B=0.
  - wrap=1 on the cycle following the event and is 0 otherwise. It is never asserted by a load.
- Arithmetic is unsigned and truncated to WIDTH bits, with no carry output.
- Every count step changes exactly one bit of gray_out, including the wrap step. A load may change any number of bits.
- A direction change takes effect on the next enabled step, with no idle cycle.
- Reset mid-operation clears state on that edge, and a pending wrap is dropped.

## Timing
- Reset values: bin_out=0, gray_out=0, wrap=0.
- Latency: an input sampled at edge N is reflected on bin_out, gray_out and wrap immediately after edge N. This is one register stage.
- No combinational path runs from any input to any output.
- Throughput is one step per clock while en=1.
- When load and en arrive together, load wins and no step occurs that cycle.
- gray_out is glitch-free by construction, because it is driven directly from flops. It is safe to synchronise it into another domain.

## Configuration
- Macro GRAY_COUNTER_SAT_EN.
- When it is undefined, the counter wraps modulo 2^WIDTH at a terminal-count event, as described in Operation.
- When it is defined, the counter saturates at a terminal-count event:
  - B holds at 2^WIDTH-1 when counting up and at 0 when counting down.
  - gray_out does not change.
  - wrap still pulses for one cycle on every enabled attempt made at the limit, so it pulses continuously while en is held at the limit.
- Load and reset behaviour is identical in both builds.

## Test plan
- Reset and up-count, WIDTH=4:
  - Stimulus: rst for 2 cycles, then en=1, up=1 for 17 cycles.
  - Required response: bin_out=0 and gray_out=0 after reset.
  - gray_out steps through 1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0.
  - wrap=1 only on the cycle where gray_out returns from 8 to 0, and gray_out changes by a Hamming distance of 1 on every step.
- Load and down-count:
  - Stimulus: load=1 with load_val=5, then en=1, up=0 for 6 cycles.
  - Required response: after the load, bin_out=5, gray_out=7 and wrap=0.
  - bin_out then steps 4,3,2,1,0,F with gray_out=8 at F.
  - wrap pulses once, on the 0 to F step.
- Simultaneous load and en: with load=1, load_val=A and en=1, bin_out=A and gray_out=F; no increment occurs and wrap=0.
- Reset mid-count: assert rst while bin_out=7 and en=1. On the next cycle bin_out=0, gray_out=0 and wrap=0, and counting resumes from 0 once rst deasserts.
- Saturation build, with GRAY_COUNTER_SAT_EN defined:
  - Stimulus: load F, then up for 3 cycles; then load 0, then down for 2 cycles.
  - Required response: bin_out stays at F with wrap=1 for 3 cycles, then stays at 0 with wrap=1 for 2 cycles.
- Wide parameter: with WIDTH=12, run a random mix of en, up and load for 10k cycles. Every output must satisfy gray_out == bin_out ^ (bin_out>>1), and every non-load step must have a Hamming distance of 1.
